seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised, runtime-programmable serial pattern detector; successor to the fixed 1011 detector.
- Matches an arbitrary pattern of 1..MAX_LEN bits on a qualified serial input stream.
- Selectable overlapping or non-overlapping detection, plus a saturating match counter.
- Sits on the serial data path and feeds framing and alarm logic.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (2..32).
- LEN_W, 4: width of cfg_len; must satisfy 2^LEN_W > MAX_LEN.
- CNT_W, 8: width of match_count.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  data_in is sampled only when high.
- data_in  input  1  serial input bit.
- cfg_load  input  1  one-cycle strobe; latches cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is received first, bit [0] last.
- cfg_len  input  LEN_W  pattern length.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- count_clr  input  1  synchronous clear of match_count.
- detected  output  1  registered one-cycle pulse per match.
- match_count  output  CNT_W  saturating count of matches.
- armed  output  1  history holds at least len valid bits.

Behaviour:
- Reset (async assert, sync release on the next clk edge after reset_n rises):
  - detected=0, match_count=0, armed=0, history=0, hist_cnt=0.
  - Latched config = pattern 0, len 0, overlap 1.
- Effective length: len_eff = min(cfg_len, MAX_LEN), taken at load. len_eff=0 disables detection; state stays IDLE.
- State machine:
  - IDLE: len_eff=0 -> stays in IDLE.
  - FILL: hist_cnt < len_eff -> goes to ARMED when hist_cnt reaches len_eff.
  - ARMED: comparison active; armed=1 only in this state.
  - cfg_load from any state -> FILL, or IDLE if the new len_eff=0.
- Sampling: on in_valid=1, the shift register does history <= {history[MAX_LEN-2:0], data_in}; hist_cnt increments and saturates at MAX_LEN. in_valid=0 holds everything; gaps in in_valid do not break a match.
- Match condition, evaluated on the shifted-in value: state ARMED after the shift, and history[len_eff-1:0] == cfg_pattern[len_eff-1:0].
- Latency: detected rises on the clk edge after the edge that samples the last pattern bit. It is high for exactly one cycle per match.
- Overlap=1: history is retained after a match. Example: 1011011 with pattern 1011 gives 2 matches.
- Overlap=0: on a match, hist_cnt is cleared to 0 and the state goes to FILL. The next match needs len_eff fresh bits; the same example gives 1 match.
- match_count: increments by 1 per match and saturates at 2^CNT_W-1 (no wrap).
- Simultaneous events:
  - cfg_load with in_valid: the load wins, the bit is discarded, history and hist_cnt are cleared, and no match is evaluated that cycle.
  - cfg_load does not clear match_count.
  - count_clr with a match: the clear wins, match_count=0, but detected still pulses.
- Pattern bits above len_eff are ignored in comparison.
- Reset mid-pattern: partial history is lost; detection restarts from FILL only after a cfg_load. Config also returns to len 0, so the block sits in IDLE.

Decomposition:
- Shared package seq_det_pkg: state enum (IDLE, FILL, ARMED) and a default CNT_W constant.
- One natural sub-module: seq_match_cmp, a combinational masked comparator of history vs. pattern by len_eff.
- The FSM, shift register and counter stay in the top module.

Test Plan:
1. Reset, load pattern 8'b00001011, len 4, overlap 1; drive 1,0,1,1 with in_valid=1 -> detected pulses one cycle after the 4th bit; match_count=1.
2. Same config, stream 1,0,1,1,0,1,1 -> two detected pulses, 3 cycles apart; match_count=2. Reload with overlap=0 and repeat -> one pulse; match_count=3.
3. Pattern 1011 with in_valid low for 3 cycles between bits 2 and 3 -> a single pulse after the final bit; no pulse during the gaps; armed=0 until 4 bits are seen.
4. CNT_W=2, six matches -> match_count reaches 3 and holds at 3. Assert count_clr in the same cycle as a match -> match_count=0 and detected=1.
5. cfg_load asserted with in_valid=1 mid-stream (3 bits into 1011) -> no detection from the old partial history; the new pattern 8'b11001010, len 8 matches after 8 fresh bits.
6. cfg_len=0 loaded -> no pulses on any stream and armed=0. cfg_len=15 with MAX_LEN=8 -> len clamps to 8 and an 8-bit pattern detects. Pull reset_n low mid-stream -> all outputs drop to 0 immediately, with no clk edge needed.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_CNT_W = 8;

endpackage

// File: rtl/seq_match_cmp.sv
// Masked comparator: compares the low len bits of history against pattern.
module seq_match_cmp
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4
) (
  input  logic [MAX_LEN-1:0] history,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               equal
);

  logic [MAX_LEN-1:0] mask;

  // Build a mask of the low len bits and compare only those positions.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < 32'(len));
    end
    equal = ((history ^ pattern) & mask) == '0;
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlap control and a
// saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic               data_in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               count_clr,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);

  state_t             state, state_nxt;
  logic [MAX_LEN-1:0] history, history_nxt, shifted, pattern;
  logic [LEN_W-1:0]   hist_cnt, hist_cnt_nxt, hist_cnt_inc, len_eff, len_new;
  logic               overlap;
  logic               match, hit, cmp_eq;

  assign shifted      = {history[MAX_LEN-2:0], data_in};
  assign len_new      = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
  assign hist_cnt_inc = (hist_cnt == LEN_W'(MAX_LEN)) ? hist_cnt : hist_cnt + LEN_W'(1);
  assign armed        = (state == ARMED);

  seq_match_cmp #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cmp (
    .history (shifted),
    .pattern (pattern),
    .len     (len_eff),
    .equal   (cmp_eq)
  );

  // Latch the configuration on cfg_load, clamping the length to MAX_LEN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern <= '0;
      len_eff <= '0;
      overlap <= 1'b1;
    end else if (cfg_load) begin
      pattern <= cfg_pattern;
      len_eff <= len_new;
      overlap <= cfg_overlap;
    end
  end

  // Next state, shift register and match evaluation on the shifted-in value.
  // A match is judged against the post-shift state, so the FILL->ARMED step
  // and the comparison happen on the same sampling edge.
  always_comb begin
    state_nxt    = state;
    history_nxt  = history;
    hist_cnt_nxt = hist_cnt;
    match        = 1'b0;
    if (cfg_load) begin
      history_nxt  = '0;
      hist_cnt_nxt = '0;
      state_nxt    = (len_new == '0) ? IDLE : FILL;
    end else if (in_valid) begin
      history_nxt  = shifted;
      hist_cnt_nxt = hist_cnt_inc;
      if (state == FILL && hist_cnt_inc >= len_eff) begin
        state_nxt = ARMED;
      end
      if (state_nxt == ARMED && cmp_eq) begin
        match = 1'b1;
        if (!overlap) begin
          hist_cnt_nxt = '0;
          state_nxt    = FILL;
        end
      end
    end
  end

  // State, history and fill-count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      history  <= '0;
      hist_cnt <= '0;
    end else begin
      state    <= state_nxt;
      history  <= history_nxt;
      hist_cnt <= hist_cnt_nxt;
    end
  end

  // Two-stage pulse so detected rises one edge after the last bit is sampled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit      <= 1'b0;
      detected <= 1'b0;
    end else begin
      hit      <= match;
      detected <= hit;
    end
  end

  // Saturating match counter; a clear takes priority over a same-cycle match.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_count <= '0;
    end else if (count_clr) begin
      match_count <= '0;
    end else if (match && match_count != '1) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: a wide-counter instance and a
// 2-bit-counter instance share all inputs.
module tb_seq_detector_param;

  logic       clk, reset_n, in_valid, data_in, cfg_load, cfg_overlap, count_clr;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       detected, armed, detected2, armed2;
  logic [7:0] match_count;
  logic [1:0] match_count2;

  typedef struct {
    int cyc;
    int cnt;
    int cnt2;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_cnt = 0;
  int   exp_cnt2 = 0;

  seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .data_in(data_in),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .count_clr(count_clr), .detected(detected),
    .match_count(match_count), .armed(armed)
  );

  seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .data_in(data_in),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .count_clr(count_clr), .detected(detected2),
    .match_count(match_count2), .armed(armed2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every pulse from either instance consumes one expected entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && (detected || detected2)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("detected_wide", int'(detected), 1);
        chk("detected_narrow", int'(detected2), 1);
        chk("match_count", int'(match_count), e.cnt);
        chk("match_count_sat", int'(match_count2), e.cnt2);
      end
    end
  end

  // Drive one cycle; m marks a hand-computed match on this sample.
  task automatic step(input logic v, input logic b, input bit m, input bit clr = 1'b0);
    in_valid  = v;
    data_in   = b;
    count_clr = clr;
    if (clr) begin
      exp_cnt  = 0;
      exp_cnt2 = 0;
    end else if (m) begin
      exp_cnt  = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      exp_cnt2 = (exp_cnt2 == 3) ? 3 : exp_cnt2 + 1;
    end
    if (m) sb.push_back('{cyc + 2, exp_cnt, exp_cnt2});
    @(posedge clk);
    #1;
    count_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                      input bit clr = 1'b0);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_load    = 1'b1;
    step(1'b0, 1'b0, 1'b0, clr);
    cfg_load    = 1'b0;
  endtask

  // Send n bits MSB first; mk bit i flags a match on bit i.
  task automatic send(input logic [31:0] bits, input int n, input logic [31:0] mk);
    logic [31:0] b, m;
    b = bits;
    m = mk;
    for (int i = n - 1; i >= 0; i--) step(1'b1, b[i], m[i]);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; data_in = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; count_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);
    chk("reset_detected", int'(detected), 0);
    chk("reset_count", int'(match_count), 0);
    chk("reset_armed", int'(armed), 0);

    // 1011, overlapping
    load(8'b0000_1011, 4'd4, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("armed_after_3", int'(armed), 0);
    step(1'b1, 1'b1, 1'b1);
    chk("armed_after_4", int'(armed), 1);
    idle(3);

    // 1011011 overlapping -> matches at bits 4 and 7; then non-overlapping -> one
    load(8'b0000_1011, 4'd4, 1'b1, 1'b1);
    send(32'b1011011, 7, 32'b0001001);
    idle(3);
    load(8'b0000_1011, 4'd4, 1'b0);
    send(32'b1011011, 7, 32'b0001000);
    idle(3);

    // gaps in in_valid do not break the match
    load(8'b0000_1011, 4'd4, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("armed_before_gap", int'(armed), 0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("armed_in_gap", int'(armed), 0);
    step(1'b1, 1'b1, 1'b0);
    chk("armed_after_3_gap", int'(armed), 0);
    step(1'b1, 1'b1, 1'b1);
    chk("armed_after_4_gap", int'(armed), 1);
    idle(3);

    // counter saturation on the 2-bit instance, then clear racing a match
    load(8'b0000_0011, 4'd2, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) send(32'b11, 2, 32'b01);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    idle(3);
    chk("count_after_clr", int'(match_count), 0);
    chk("count_sat_after_clr", int'(match_count2), 0);

    // reload mid-pattern with a bit present: old partial history is dropped
    load(8'b0000_1011, 4'd4, 1'b1);
    send(32'b101, 3, 32'b0);
    cfg_pattern = 8'b1100_1010;
    cfg_len     = 4'd8;
    cfg_overlap = 1'b1;
    cfg_load    = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    cfg_load    = 1'b0;
    send(32'b110_0101, 7, 32'b0);
    chk("armed_after_7_of_8", int'(armed), 0);
    step(1'b1, 1'b0, 1'b1);
    chk("armed_after_8_of_8", int'(armed), 1);
    idle(3);

    // length 0 disables detection
    load(8'b0000_0000, 4'd0, 1'b1);
    send(32'b101100, 6, 32'b0);
    chk("armed_len0", int'(armed), 0);
    idle(3);

    // length 15 clamps to 8
    load(8'b1010_0101, 4'd15, 1'b1);
    send(32'b1010_0101, 8, 32'b1);
    chk("armed_len_clamped", int'(armed), 1);
    send(32'b10, 2, 32'b0);
    idle(3);

    // asynchronous reset mid-stream
    in_valid = 1'b1;
    data_in  = 1'b1;
    #3;
    chk("armed_before_reset", int'(armed), 1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_armed", int'(armed), 0);
    chk("async_reset_count", int'(match_count), 0);
    chk("async_reset_detected", int'(detected), 0);
    chk("async_reset_count_sat", int'(match_count2), 0);
    exp_cnt  = 0;
    exp_cnt2 = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    send(32'b1011_0000, 8, 32'b0);
    chk("armed_after_reset", int'(armed), 0);
    idle(4);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
